// File: rtl/reaction_game_ctrl_pkg.sv
// Shared types and constants for the reaction-time game round sequencer.
package reaction_game_ctrl_pkg;

  localparam int unsigned TW = 13;

  typedef logic [TW-1:0] ms_t;

  localparam ms_t BEST_INIT = 13'h1FFF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RNG,
    DELAY,
    GO,
    DONE,
    FOUL
  } state_t;

endpackage

// File: rtl/reaction_game_ctrl_ms_tick_gen.sv
// Millisecond prescaler: counts 0..MS_DIV-1 and flags the last count as tick.
module ms_tick_gen #(
  parameter int unsigned MS_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(MS_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/reaction_game_ctrl.sv
// One round of the reaction game: random delay, GO lamp, latency measurement,
// foul/timeout detection and best-time tracking.
module reaction_game_ctrl
  import reaction_game_ctrl_pkg::*;
#(
  parameter int unsigned MS_DIV     = 100000,
  parameter int unsigned TIMEOUT_MS = 2000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          press,
  input  logic [TW-1:0] rand_num,
  output logic          rand_new,
  output logic          led_go,
  output logic [TW-1:0] react_ms,
  output logic          result_valid,
  output logic          too_early,
  output logic          timeout,
  output logic [TW-1:0] best_ms,
  output logic          busy
);

  localparam ms_t TMO = ms_t'(TIMEOUT_MS);

  state_t state, state_n;
  logic   start_q, press_q;
  logic   start_e, press_e;
  logic   tick, tick_clr;
  ms_t    delay_cnt, delay_n;
  ms_t    rt_cnt, rt_n;
  ms_t    react_n, best_n;
  logic   valid_n, early_n, tmo_n;

  assign start_e = start & ~start_q;
  assign press_e = press & ~press_q;

  ms_tick_gen #(.MS_DIV(MS_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    delay_n = delay_cnt;
    rt_n    = rt_cnt;
    react_n = react_ms;
    best_n  = best_ms;
    valid_n = result_valid;
    early_n = too_early;
    tmo_n   = timeout;
    unique case (state)
      IDLE: if (start_e) state_n = REQ;
      REQ: begin
        state_n = WAIT_RNG;
        valid_n = 1'b0;
        early_n = 1'b0;
        tmo_n   = 1'b0;
        react_n = '0;
      end
      WAIT_RNG: begin
        state_n = DELAY;
        delay_n = (rand_num == '0) ? ms_t'(1) : rand_num;
      end
      DELAY: begin
        // a press beats expiry when both land on the same cycle
        if (press_e) begin
          state_n = FOUL;
          early_n = 1'b1;
          react_n = '0;
        end else if (tick) begin
          if (delay_cnt == ms_t'(1)) begin
            state_n = GO;
            rt_n    = '0;
          end else begin
            delay_n = delay_cnt - ms_t'(1);
          end
        end
      end
      GO: begin
        if (press_e) begin
          state_n = DONE;
          react_n = rt_cnt;
          valid_n = 1'b1;
          if (rt_cnt < best_ms) best_n = rt_cnt;
        end else if (tick) begin
          if (rt_cnt + ms_t'(1) == TMO) begin
            state_n = DONE;
            rt_n    = TMO;
            react_n = TMO;
            tmo_n   = 1'b1;
          end else begin
            rt_n = rt_cnt + ms_t'(1);
          end
        end
      end
      DONE, FOUL: if (start_e) state_n = REQ;
      default: state_n = IDLE;
    endcase
    // restart the prescaler on entry so the first ms of each phase is full length
    tick_clr = ((state_n == DELAY) && (state != DELAY)) ||
               ((state_n == GO) && (state != GO));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      press_q      <= 1'b0;
      delay_cnt    <= '0;
      rt_cnt       <= '0;
      rand_new     <= 1'b0;
      led_go       <= 1'b0;
      react_ms     <= '0;
      result_valid <= 1'b0;
      too_early    <= 1'b0;
      timeout      <= 1'b0;
      best_ms      <= BEST_INIT;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      start_q      <= start;
      press_q      <= press;
      delay_cnt    <= delay_n;
      rt_cnt       <= rt_n;
      rand_new     <= (state_n == REQ);
      led_go       <= (state_n == GO);
      react_ms     <= react_n;
      result_valid <= valid_n;
      too_early    <= early_n;
      timeout      <= tmo_n;
      best_ms      <= best_n;
      busy         <= (state_n == REQ) || (state_n == WAIT_RNG) ||
                      (state_n == DELAY) || (state_n == GO);
    end
  end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed self-checking bench for reaction_game_ctrl with MS_DIV=4.
module tb_reaction_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        press = 1'b0;
  logic [12:0] rand_num = '0;
  logic        rand_new, led_go, result_valid, too_early, timeout, busy;
  logic [12:0] react_ms, best_ms;

  int checks = 0;
  int passed = 0;

  reaction_game_ctrl #(.MS_DIV(4), .TIMEOUT_MS(2000)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .press        (press),
    .rand_num     (rand_num),
    .rand_new     (rand_new),
    .led_go       (led_go),
    .react_ms     (react_ms),
    .result_valid (result_valid),
    .too_early    (too_early),
    .timeout      (timeout),
    .best_ms      (best_ms),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Ends one cycle after the DUT sees the start edge (state REQ).
  task automatic pulse_start(input logic [12:0] r);
    rand_num = r;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic press_pulse();
    press = 1'b1;
    step(1);
    press = 1'b0;
  endtask

  task automatic wait_led(input int budget, output int n);
    n = -1;
    for (int i = 0; i < budget; i++) begin
      if (led_go) begin
        n = i;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (rand_new !== 1'b0) $display("FAIL reset_rand_new: got %0b want 0", rand_new); else passed++;
    checks++; if (led_go !== 1'b0) $display("FAIL reset_led_go: got %0b want 0", led_go); else passed++;
    checks++; if (react_ms !== 13'd0) $display("FAIL reset_react: got %0d want 0", react_ms); else passed++;
    checks++; if ({result_valid, too_early, timeout} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {result_valid, too_early, timeout}); else passed++;
    checks++; if (best_ms !== 13'h1FFF) $display("FAIL reset_best: got %h want 1fff", best_ms); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    step(3);
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %0b want 0", busy); else passed++;
  endtask

  task automatic test_valid_round();
    pulse_start(13'd500);
    checks++; if (rand_new !== 1'b1) $display("FAIL req_rand_new: got %0b want 1", rand_new); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL req_busy: got %0b want 1", busy); else passed++;
    step(1);
    checks++; if (rand_new !== 1'b0) $display("FAIL rand_new_width: got %0b want 0", rand_new); else passed++;
    step(1);
    step(1999);
    checks++; if (led_go !== 1'b0) $display("FAIL go_early: got %0b want 0", led_go); else passed++;
    step(1);
    checks++; if (led_go !== 1'b1) $display("FAIL go_rise: got %0b want 1", led_go); else passed++;
    step(4 * 37);
    press_pulse();
    checks++; if (result_valid !== 1'b1) $display("FAIL valid_flag: got %0b want 1", result_valid); else passed++;
    checks++; if (react_ms !== 13'd37) $display("FAIL valid_react: got %0d want 37", react_ms); else passed++;
    checks++; if (best_ms !== 13'd37) $display("FAIL valid_best: got %0d want 37", best_ms); else passed++;
    checks++; if ({led_go, timeout, too_early, busy} !== 4'b0000) $display("FAIL valid_others: got %b want 0000", {led_go, timeout, too_early, busy}); else passed++;
  endtask

  task automatic test_foul();
    pulse_start(13'd800);
    step(2);
    step(10);
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++; if (rand_new !== 1'b0) $display("FAIL delay_start_ignored: got %0b want 0", rand_new); else passed++;
    step(3);
    checks++; if ({rand_new, busy} !== 2'b01) $display("FAIL delay_start_state: got %b want 01", {rand_new, busy}); else passed++;
    step(386);
    press_pulse();
    checks++; if (too_early !== 1'b1) $display("FAIL foul_flag: got %0b want 1", too_early); else passed++;
    checks++; if ({result_valid, timeout, led_go, busy} !== 4'b0000) $display("FAIL foul_others: got %b want 0000", {result_valid, timeout, led_go, busy}); else passed++;
    checks++; if (react_ms !== 13'd0) $display("FAIL foul_react: got %0d want 0", react_ms); else passed++;
    checks++; if (best_ms !== 13'd37) $display("FAIL foul_best: got %0d want 37", best_ms); else passed++;
    step(4000);
    checks++; if ({led_go, too_early} !== 2'b01) $display("FAIL foul_hold: got %b want 01", {led_go, too_early}); else passed++;
  endtask

  task automatic test_timeout();
    pulse_start(13'd2);
    step(2);
    step(8);
    checks++; if (led_go !== 1'b1) $display("FAIL tmo_go: got %0b want 1", led_go); else passed++;
    step(7999);
    checks++; if ({led_go, timeout} !== 2'b10) $display("FAIL tmo_before: got %b want 10", {led_go, timeout}); else passed++;
    step(1);
    checks++; if (timeout !== 1'b1) $display("FAIL tmo_flag: got %0b want 1", timeout); else passed++;
    checks++; if (react_ms !== 13'd2000) $display("FAIL tmo_react: got %0d want 2000", react_ms); else passed++;
    checks++; if ({result_valid, too_early, led_go} !== 3'b000) $display("FAIL tmo_others: got %b want 000", {result_valid, too_early, led_go}); else passed++;
    checks++; if (best_ms !== 13'd37) $display("FAIL tmo_best: got %0d want 37", best_ms); else passed++;
  endtask

  task automatic test_simultaneous();
    pulse_start(13'd10);
    step(2);
    step(39);
    press_pulse();
    checks++; if ({too_early, led_go} !== 2'b10) $display("FAIL sim_final_tick_foul: got %b want 10", {too_early, led_go}); else passed++;
    pulse_start(13'd10);
    step(2);
    step(40);
    checks++; if (led_go !== 1'b1) $display("FAIL sim_go: got %0b want 1", led_go); else passed++;
    step(167);
    press_pulse();
    checks++; if (react_ms !== 13'd41) $display("FAIL sim_tick_press_react: got %0d want 41", react_ms); else passed++;
    checks++; if ({result_valid, timeout} !== 2'b10) $display("FAIL sim_tick_press_flags: got %b want 10", {result_valid, timeout}); else passed++;
    checks++; if (best_ms !== 13'd37) $display("FAIL sim_best: got %0d want 37", best_ms); else passed++;
  endtask

  task automatic test_reset_mid_round();
    int n;
    pulse_start(13'd1234);
    step(2);
    wait_led(6000, n);
    checks++; if (n !== 4936) $display("FAIL rst_go_latency: got %0d want 4936", n); else passed++;
    step(10);
    #3;
    rst = 1'b1;
    #1;
    checks++; if ({led_go, busy, rand_new} !== 3'b000) $display("FAIL rst_async_outs: got %b want 000", {led_go, busy, rand_new}); else passed++;
    checks++; if (best_ms !== 13'h1FFF) $display("FAIL rst_async_best: got %h want 1fff", best_ms); else passed++;
    checks++; if ({react_ms, result_valid, too_early, timeout} !== 16'd0) $display("FAIL rst_async_result: got %h want 0", {react_ms, result_valid, too_early, timeout}); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);
    pulse_start(13'd3);
    checks++; if (rand_new !== 1'b1) $display("FAIL clean_rand_new: got %0b want 1", rand_new); else passed++;
    step(2);
    step(12);
    checks++; if (led_go !== 1'b1) $display("FAIL clean_go: got %0b want 1", led_go); else passed++;
    step(4 * 200);
    press_pulse();
    checks++; if (react_ms !== 13'd200) $display("FAIL clean_react: got %0d want 200", react_ms); else passed++;
    checks++; if (best_ms !== 13'd200) $display("FAIL clean_best: got %0d want 200", best_ms); else passed++;
  endtask

  task automatic test_best();
    int          rt [3]   = '{120, 90, 150};
    logic [12:0] bexp [3] = '{13'd120, 13'd90, 13'd90};
    for (int i = 0; i < 3; i++) begin
      pulse_start(13'd3);
      step(2);
      step(12);
      step(4 * rt[i]);
      press_pulse();
      checks++; if (react_ms !== 13'(rt[i])) $display("FAIL best_round%0d_react: got %0d want %0d", i, react_ms, rt[i]); else passed++;
      checks++; if (best_ms !== bexp[i]) $display("FAIL best_round%0d_best: got %0d want %0d", i, best_ms, bexp[i]); else passed++;
    end
    press_pulse();
    step(2);
    checks++; if ({result_valid, react_ms} !== {1'b1, 13'd150}) $display("FAIL done_press_ignored: got %b/%0d want 1/150", result_valid, react_ms); else passed++;
  endtask

  initial begin
    test_reset();
    test_valid_round();
    test_foul();
    test_timeout();
    test_simultaneous();
    test_reset_mid_round();
    test_best();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/reaction_game_ctrl.md
Name: reaction_game_ctrl

Overview:
Sequencer for one round of the reaction-time game, built around the m-sequence random source (500..5000 ms delay values).
- Requests a fresh random value on each start and waits that many milliseconds.
- Lights the GO lamp, then measures the player's press latency in ms.
- Flags early presses and timeouts; keeps the best time seen since reset.

Parameters:
MS_DIV, 100000, clk cycles per 1 ms tick (set to 4 in simulation)
TIMEOUT_MS, 2000, ms allowed after GO before the round ends as timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  round start request, synchronous and debounced; rising edge acts
press  in  1  player button, synchronous and debounced; rising edge acts
rand_num  in  13  random delay from the random source, in ms
rand_new  out  1  request to the random source; one-clock high pulse
led_go  out  1  GO lamp
react_ms  out  13  measured reaction time in ms
result_valid  out  1  high while a normal, non-timeout result is held
too_early  out  1  high while a foul result is held
timeout  out  1  high while a timeout result is held
best_ms  out  13  best valid reaction time since reset
busy  out  1  high in REQ, WAIT_RNG, DELAY and GO

Behaviour:
- One clock; reset is asynchronous and active-high.
- All outputs are registered.
- Reset values:
  - state IDLE
  - rand_new, led_go, result_valid, too_early, timeout, busy = 0
  - react_ms = 0
  - best_ms = 13'h1FFF
  - prescaler = 0
  - start/press edge registers = 0
- Edge detection: each of start and press has a previous-value register; edge = in & ~prev.
- ms prescaler:
  - Counts 0..MS_DIV-1; tick is the cycle it equals MS_DIV-1, then it wraps to 0.
  - Cleared on entry to DELAY and on entry to GO, so the first ms is always full length.
- States:
  - IDLE: start edge -> REQ.
  - REQ (exactly 1 cycle):
    - rand_new = 1.
    - Clears result_valid, too_early, timeout and react_ms.
    - Next state WAIT_RNG.
  - WAIT_RNG (1 cycle): rand_new = 0. On the exit edge, delay_cnt <= rand_num; 0 is loaded as 1. Next state DELAY.
  - DELAY:
    - Each tick decrements delay_cnt.
    - Tick with delay_cnt == 1 -> GO.
    - Press edge -> FOUL; this takes priority over expiry in the same cycle.
  - GO:
    - led_go = 1; rt_cnt starts at 0 and increments on each tick.
    - Press edge -> DONE; react_ms <= rt_cnt as it was before any same-cycle increment.
    - If there is no press and a tick brings rt_cnt to TIMEOUT_MS -> DONE; react_ms = TIMEOUT_MS, timeout = 1.
    - Press wins over a timeout in the same cycle.
  - DONE:
    - led_go = 0.
    - Exactly one of result_valid or timeout is set.
    - On a valid result, best_ms <= min(best_ms, react_ms), updated once at entry.
    - Start edge -> REQ.
  - FOUL:
    - too_early = 1; react_ms = 0.
    - Start edge -> REQ.
- Start edges in REQ, WAIT_RNG, DELAY and GO are ignored.
- Press edges in IDLE, REQ, WAIT_RNG, DONE and FOUL are ignored.
- Latency: from the start edge cycle, led_go rises no earlier than 3 + rand_num*MS_DIV cycles later.
- Counters are 13 bits wide. rt_cnt cannot exceed TIMEOUT_MS, so there is no wrap.
- Reset mid-round: immediate return to IDLE; best_ms reverts to 1FFF.

Decomposition:
- Shared package:
  - state enum: IDLE, REQ, WAIT_RNG, DELAY, GO, DONE, FOUL
  - 13-bit time width constant
  - BEST_INIT = 13'h1FFF
- One natural sub-module, ms_tick_gen: prescaler with synchronous clear and a tick output, parameter MS_DIV.
- The FSM, counters and result registers stay in the top.

Test Plan:
1. MS_DIV=4, rand_num=500. Start pulse, then press 37 ticks after led_go rises.
   -> rand_new pulses exactly 1 cycle; led_go rises after 500 ticks; result_valid=1; react_ms=37; best_ms=37.
2. rand_num=800. Press at tick 100 of DELAY.
   -> FOUL; too_early=1; led_go never asserts; best_ms unchanged.
3. TIMEOUT_MS=2000, no press.
   -> after 2000 ticks of GO: timeout=1, react_ms=2000, result_valid=0, best_ms unchanged.
4. Two valid rounds with reaction 120 then 90, then a third with 150.
   -> best_ms goes 120, then 90, and stays 90.
5. Simultaneous events:
   - Press edge in the same cycle as the final DELAY tick -> FOUL.
   - Press edge in the same cycle as a GO tick at rt_cnt=41 -> react_ms=41.
6. Assert rst during GO with rand_num=1234.
   -> all outputs go to reset values immediately, asynchronously; the next start runs a clean round.
   - A start edge during DELAY is ignored: no second rand_new pulse.
